// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: FSM state encodings and mode-word bit positions shared by the SPI slave.
package spi_slave_pkg;
  typedef enum logic {
    SPI_S_IDLE  = 1'b0,
    SPI_S_SHIFT = 1'b1
  } state_e;
  localparam int MODE_CPOL  = 0;
  localparam int MODE_CPHA  = 1;
  localparam int MODE_ORDER = 2;
  localparam int MODE_W     = 3;
endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: core-side TX buffer (valid/ready) and RX holding register (valid/ack) bus.
interface spi_slave_if #(parameter int DATA_W = 32) ();
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ack;
  modport master (output tx_data, tx_valid, rx_ack, input tx_ready, rx_data, rx_valid);
  modport slave  (input tx_data, tx_valid, rx_ack, output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: 2-flop synchronizers for sck/ss_n/mosi with sck and ss_n edge strobes.
module spi_slave_sync (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic ss_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_fall,
  output logic ss_rise,
  output logic mosi_s
);
  logic [2:0] sck_q, sck_d, ss_q, ss_d;
  logic [1:0] mosi_q, mosi_d;
  always_comb begin
    sck_d  = {sck_q[1:0], sck};
    ss_d   = {ss_q[1:0], ss_n};
    mosi_d = {mosi_q[0], mosi};
  end
  // ss_n resets to "selected" so a select held low through reset never looks like a fresh fall
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sck_q  <= '0;
      ss_q   <= '0;
      mosi_q <= '0;
    end else begin
      sck_q  <= sck_d;
      ss_q   <= ss_d;
      mosi_q <= mosi_d;
    end
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign ss_fall  = ~ss_q[1] & ss_q[2];
  assign ss_rise  = ss_q[1] & ~ss_q[2];
  assign mosi_s   = mosi_q[1];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI target, modes 0-3, MSB/LSB first, 1-deep TX buffer, RX holding register.
// Define SPI_SLAVE_ERR_EN to enable the sticky ovr/udr error flags.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int               DATA_W  = 32,
  parameter logic [DATA_W-1:0] TX_IDLE = '1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpol,
  input  logic        cpha,
  input  logic        order,
  input  logic        sck,
  input  logic        ss_n,
  input  logic        mosi,
  output logic        miso_o,
  output logic        miso_t,
  spi_slave_if.slave  bus,
  output logic        busy,
  output logic        abort,
  output logic        ovr,
  output logic        udr,
  input  logic        err_clr
);
  localparam int CW = $clog2(DATA_W) + 1;
  logic sck_rise, sck_fall, ss_fall, ss_rise, mosi_s;
  spi_slave_sync u_sync (
    .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_n), .mosi(mosi),
    .sck_rise(sck_rise), .sck_fall(sck_fall), .ss_fall(ss_fall), .ss_rise(ss_rise), .mosi_s(mosi_s)
  );
  state_e              state_q, state_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, tx_buf_q, tx_buf_d, rx_data_q, rx_data_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                tx_full_q, tx_full_d, rx_valid_q, rx_valid_d, abort_q, abort_d;
  logic                lead, trail, smp, shf, start, done, load;
  logic [DATA_W-1:0]   rx_nx, tx_nx;
  always_comb begin
    lead       = mode_q[MODE_CPOL] ? sck_fall : sck_rise;
    trail      = mode_q[MODE_CPOL] ? sck_rise : sck_fall;
    start      = state_q == SPI_S_IDLE && ss_fall;
    smp        = state_q == SPI_S_SHIFT && !ss_rise && (mode_q[MODE_CPHA] ? trail : lead);
    // no shift before the first sample of a frame: the first bit is already on miso after a load
    shf        = state_q == SPI_S_SHIFT && !ss_rise && cnt_q != '0 && (mode_q[MODE_CPHA] ? lead : trail);
    rx_nx      = mode_q[MODE_ORDER] ? {mosi_s, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], mosi_s};
    tx_nx      = mode_q[MODE_ORDER] ? {1'b1, tx_sh_q[DATA_W-1:1]} : {tx_sh_q[DATA_W-2:0], 1'b1};
    done       = smp && cnt_q == CW'(DATA_W - 1);
    load       = start || done;
    state_d    = state_q;
    mode_d     = mode_q;
    tx_sh_d    = shf ? tx_nx : tx_sh_q;
    rx_sh_d    = smp ? rx_nx : rx_sh_q;
    cnt_d      = smp ? (done ? '0 : cnt_q + 1'b1) : cnt_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    rx_data_d  = done ? rx_nx : rx_data_q;
    rx_valid_d = done ? 1'b1 : (bus.rx_ack ? 1'b0 : rx_valid_q);
    abort_d    = 1'b0;
    if (start) begin
      state_d            = SPI_S_SHIFT;
      mode_d[MODE_CPOL]  = cpol;
      mode_d[MODE_CPHA]  = cpha;
      mode_d[MODE_ORDER] = order;
      cnt_d              = '0;
    end
    if (state_q == SPI_S_SHIFT && ss_rise) begin
      state_d = SPI_S_IDLE;
      abort_d = cnt_q != '0;
      cnt_d   = '0;
    end
    if (load) begin
      tx_sh_d   = tx_full_q ? tx_buf_q : TX_IDLE;
      tx_full_d = 1'b0;
    end
    // a write into an empty buffer on a load cycle is kept for the following frame
    if (bus.tx_valid && !tx_full_q) begin
      tx_buf_d  = bus.tx_data;
      tx_full_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= SPI_S_IDLE;
      mode_q     <= '0;
      tx_sh_q    <= '1;
      rx_sh_q    <= '0;
      tx_buf_q   <= '0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      tx_full_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      tx_buf_q   <= tx_buf_d;
      rx_data_q  <= rx_data_d;
      cnt_q      <= cnt_d;
      tx_full_q  <= tx_full_d;
      rx_valid_q <= rx_valid_d;
      abort_q    <= abort_d;
    end
  assign miso_o       = state_q == SPI_S_IDLE ? 1'b1 : (mode_q[MODE_ORDER] ? tx_sh_q[0] : tx_sh_q[DATA_W-1]);
  assign miso_t       = state_q == SPI_S_IDLE;
  assign busy         = state_q == SPI_S_SHIFT;
  assign abort        = abort_q;
  assign bus.tx_ready = !tx_full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
`ifdef SPI_SLAVE_ERR_EN
  logic ovr_q, ovr_d, udr_q, udr_d;
  always_comb begin
    ovr_d = (done && rx_valid_q) || (ovr_q && !err_clr);
    udr_d = (load && !tx_full_q) || (udr_q && !err_clr);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovr_q <= 1'b0;
      udr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
      udr_q <= udr_d;
    end
  assign ovr = ovr_q;
  assign udr = udr_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovr = 1'b0;
  assign udr = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives an SPI master model against spi_slave and checks against a transaction-level model.
module tb_spi_slave;
  localparam int W = 32;
`ifdef SPI_SLAVE_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic cpol = 1'b0, cpha = 1'b0, order = 1'b0, sck = 1'b0, ss_n = 1'b1, mosi = 1'b0, err_clr = 1'b0;
  logic miso_o, miso_t, busy, abort, ovr, udr;
  spi_slave_if #(.DATA_W(W)) bus ();
  spi_slave #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .order(order), .sck(sck), .ss_n(ss_n),
    .mosi(mosi), .miso_o(miso_o), .miso_t(miso_t), .bus(bus), .busy(busy), .abort(abort),
    .ovr(ovr), .udr(udr), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  int n_checks = 0, n_fail = 0, abort_cnt = 0;
  logic [W-1:0] txq[$];
  logic rxv_m = 1'b0, ovr_m = 1'b0, udr_m = 1'b0;
  always @(negedge clk) if (abort === 1'b1) abort_cnt++;
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, summary forced");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end
  // reference model: every frame load takes the next queued word or the all-ones idle word
  function automatic logic [W-1:0] next_tx();
    if (txq.size() == 0) begin
      udr_m = 1'b1;
      return '1;
    end
    return txq.pop_front();
  endfunction
  function automatic void model_done();
    if (rxv_m) ovr_m = 1'b1;
    rxv_m = 1'b1;
    void'(next_tx());
  endfunction
  task automatic half();
    repeat (4) @(negedge clk);
  endtask
  task automatic set_mode(input int m);
    cpol = m[0]; cpha = m[1]; order = m[2]; sck = m[0];
    half();
  endtask
  task automatic tx_write(input logic [W-1:0] w);
    int k = 0;
    while (bus.tx_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    n_checks++;
    if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_ready_wait: tx_ready=%b required 1", bus.tx_ready); end
    bus.tx_data = w; bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    txq.push_back(w);
  endtask
  task automatic ack();
    bus.rx_ack = 1'b1; @(negedge clk); bus.rx_ack = 1'b0; rxv_m = 1'b0;
  endtask
  task automatic clr_err();
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; ovr_m = 1'b0; udr_m = 1'b0;
  endtask
  task automatic spi_begin();
    sck = cpol; ss_n = 1'b0;
    half();
  endtask
  task automatic spi_end();
    half(); ss_n = 1'b1; half(); half();
  endtask
  task automatic spi_word(input logic [W-1:0] mo, input int nbits, output logic [W-1:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      int p;
      p = order ? i : W - 1 - i;
      if (!cpha) begin
        mosi = mo[p]; half(); sck = ~cpol; mi[p] = miso_o; half(); sck = cpol;
      end else begin
        sck = ~cpol; mosi = mo[p]; half(); sck = cpol; mi[p] = miso_o; half();
      end
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (miso_o !== 1'b1) begin n_fail++; $display("FAIL reset_miso_o: got %b required 1", miso_o); end
    n_checks++; if (miso_t !== 1'b1) begin n_fail++; $display("FAIL reset_miso_t: got %b required 1", miso_t); end
    n_checks++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b required 1", bus.tx_ready); end
    n_checks++; if (bus.rx_data !== '0) begin n_fail++; $display("FAIL reset_rx_data: got %h required 0", bus.rx_data); end
    n_checks++; if ({bus.rx_valid, busy, abort, ovr, udr} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b required 00000", {bus.rx_valid, busy, abort, ovr, udr}); end
    rst = 1'b0;
    half();
  endtask
  task automatic test_mode0();
    logic [W-1:0] e, mi;
    set_mode(0);
    tx_write(32'hA5C3_0F81);
    e = next_tx();
    spi_begin();
    n_checks++; if ({busy, miso_t} !== 2'b10) begin n_fail++; $display("FAIL mode0_busy_miso_t: got %b required 10", {busy, miso_t}); end
    spi_word(32'h1234_5678, W, mi);
    model_done();
    spi_end();
    n_checks++; if (mi !== e) begin n_fail++; $display("FAIL mode0_miso: got %h required %h", mi, e); end
    n_checks++; if (bus.rx_data !== 32'h1234_5678) begin n_fail++; $display("FAIL mode0_rx_data: got %h required 12345678", bus.rx_data); end
    n_checks++; if (bus.rx_valid !== rxv_m) begin n_fail++; $display("FAIL mode0_rx_valid: got %b required %b", bus.rx_valid, rxv_m); end
    n_checks++; if ({busy, miso_t} !== 2'b01) begin n_fail++; $display("FAIL mode0_idle: got %b required 01", {busy, miso_t}); end
    ack();
    n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL mode0_ack: rx_valid=%b required 0", bus.rx_valid); end
  endtask
  task automatic test_modes();
    logic [W-1:0] e, mi, mo;
    for (int m = 0; m < 8; m++)
      for (int r = 0; r < 2; r++) begin
        mo = r ? $urandom : 32'h1234_5678;
        set_mode(m);
        tx_write(r ? $urandom : 32'hA5C3_0F81);
        e = next_tx();
        spi_begin();
        spi_word(mo, W, mi);
        model_done();
        spi_end();
        n_checks++; if (mi !== e) begin n_fail++; $display("FAIL modes_miso m=%0d r=%0d: got %h required %h", m, r, mi, e); end
        n_checks++; if (bus.rx_data !== mo) begin n_fail++; $display("FAIL modes_rx_data m=%0d r=%0d: got %h required %h", m, r, bus.rx_data, mo); end
        ack();
      end
  endtask
  task automatic test_underrun();
    logic [W-1:0] e, mi;
    set_mode(0);
    clr_err();
    e = next_tx();
    spi_begin();
    spi_word(32'h0000_00FF, W, mi);
    model_done();
    spi_end();
    n_checks++; if (mi !== e) begin n_fail++; $display("FAIL underrun_miso: got %h required %h", mi, e); end
    n_checks++; if (bus.rx_data !== 32'h0000_00FF) begin n_fail++; $display("FAIL underrun_rx_data: got %h required 000000ff", bus.rx_data); end
    n_checks++; if (udr !== (ERR & udr_m)) begin n_fail++; $display("FAIL underrun_udr: got %b required %b", udr, ERR & udr_m); end
    n_checks++; if (ovr !== (ERR & ovr_m)) begin n_fail++; $display("FAIL underrun_ovr: got %b required %b", ovr, ERR & ovr_m); end
    clr_err();
    n_checks++; if (udr !== 1'b0) begin n_fail++; $display("FAIL underrun_clr: udr=%b required 0", udr); end
    ack();
  endtask
  task automatic test_back_to_back();
    logic [W-1:0] e1, e2, m1, m2, mi1, mi2;
    for (int k = 0; k < 2; k++) begin
      m1 = $urandom; m2 = $urandom;
      set_mode(k ? 3 : 0);
      clr_err();
      tx_write($urandom);
      e1 = next_tx();
      spi_begin();
      tx_write($urandom);
      spi_word(m1, W, mi1);
      e2 = txq.size() ? txq[0] : '1;
      model_done();
      spi_word(m2, W, mi2);
      model_done();
      spi_end();
      n_checks++; if (mi1 !== e1 || mi2 !== e2) begin n_fail++; $display("FAIL b2b_miso k=%0d: got %h %h required %h %h", k, mi1, mi2, e1, e2); end
      n_checks++; if (bus.rx_data !== m2) begin n_fail++; $display("FAIL b2b_rx_data k=%0d: got %h required %h", k, bus.rx_data, m2); end
      n_checks++; if (bus.rx_valid !== rxv_m) begin n_fail++; $display("FAIL b2b_rx_valid k=%0d: got %b required %b", k, bus.rx_valid, rxv_m); end
      n_checks++; if (ovr !== (ERR & ovr_m) || udr !== (ERR & udr_m)) begin n_fail++; $display("FAIL b2b_flags k=%0d: ovr=%b udr=%b required %b %b", k, ovr, udr, ERR & ovr_m, ERR & udr_m); end
      clr_err();
      n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL b2b_ovr_clr k=%0d: ovr=%b required 0", k, ovr); end
      ack();
    end
  endtask
  task automatic test_abort();
    logic [W-1:0] e, mi, m0, m1;
    int a0;
    m0 = $urandom; m1 = $urandom;
    set_mode(0);
    tx_write($urandom);
    e = next_tx();
    spi_begin(); spi_word(m0, W, mi); model_done(); spi_end();
    tx_write($urandom);
    e = next_tx();
    spi_begin();
    spi_word($urandom, 13, mi);
    a0 = abort_cnt;
    spi_end();
    n_checks++; if (((mi ^ e) & 32'hFFF8_0000) !== '0) begin n_fail++; $display("FAIL abort_partial_miso: got %h required top bits of %h", mi, e); end
    n_checks++; if (abort_cnt - a0 !== 1) begin n_fail++; $display("FAIL abort_pulses: got %0d required 1", abort_cnt - a0); end
    n_checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== m0) begin n_fail++; $display("FAIL abort_rx_kept: valid=%b data=%h required 1 %h", bus.rx_valid, bus.rx_data, m0); end
    ack();
    tx_write($urandom);
    e = next_tx();
    spi_begin(); spi_word(m1, W, mi); model_done(); spi_end();
    n_checks++; if (mi !== e || bus.rx_data !== m1) begin n_fail++; $display("FAIL abort_next_frame: miso=%h rx=%h required %h %h", mi, bus.rx_data, e, m1); end
  endtask
  task automatic test_rst_mid();
    logic [W-1:0] e, mi, mo;
    mo = $urandom;
    set_mode(2);
    tx_write($urandom);
    e = next_tx();
    spi_begin();
    spi_word($urandom, 10, mi);
    @(negedge clk);
    rst = 1'b1;
    #1;
    txq.delete(); rxv_m = 1'b0; ovr_m = 1'b0; udr_m = 1'b0;
    n_checks++; if ({miso_o, miso_t, bus.tx_ready} !== 3'b111) begin n_fail++; $display("FAIL rst_mid_pins: got %b required 111", {miso_o, miso_t, bus.tx_ready}); end
    n_checks++; if ({bus.rx_valid, busy, abort, ovr, udr} !== 5'b0 || bus.rx_data !== '0) begin n_fail++; $display("FAIL rst_mid_state: flags=%b rx=%h required 00000 0", {bus.rx_valid, busy, abort, ovr, udr}, bus.rx_data); end
    @(negedge clk);
    rst = 1'b0;
    ss_n = 1'b1; sck = cpol;
    half(); half();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_restart: busy=%b required 0", busy); end
    tx_write($urandom);
    e = next_tx();
    spi_begin(); spi_word(mo, W, mi); model_done(); spi_end();
    n_checks++; if (mi !== e || bus.rx_data !== mo || bus.rx_valid !== rxv_m) begin n_fail++; $display("FAIL rst_mid_next_frame: miso=%h rx=%h v=%b required %h %h %b", mi, bus.rx_data, bus.rx_valid, e, mo, rxv_m); end
  endtask
  initial begin
    bus.tx_data = '0; bus.tx_valid = 1'b0; bus.rx_ack = 1'b0;
    test_reset();
    test_mode0();
    test_modes();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
